// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared channel state type and default parameters for the button conditioner
package btn_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } btn_state_t;

    localparam int N_BTN_DEF           = 3;
    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;

endpackage

// File: rtl/btn_debounce_ch.sv
// rtl/btn_debounce_ch.sv - one button channel: synchronizer, debounce FSM and press pulse
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rstn,
    input  logic raw,
    output logic clean_n,
    output logic pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_lvl;
    btn_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q  <= '1;
            state_q <= RELEASED;
            cnt_q   <= '0;
            clean_n <= 1'b1;
            pulse   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // Outputs are registered from the next state so they line up with the state change.
            clean_n <= !((state_d == HELD) || (state_d == RELEASE_WAIT));
            pulse   <= (state_q == PRESS_WAIT) && (state_d == HELD);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RELEASED: begin
                if (!sync_lvl) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (sync_lvl) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (sync_lvl) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (!sync_lvl) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - per-button debounce channels plus optional multi-press filter (BTN_MULTI_REJECT_EN)
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN           = N_BTN_DEF,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_n_clean,
    output logic [N_BTN-1:0] press_pulse,
    output logic             multi_press
);

    logic [N_BTN-1:0] ch_pulse;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk     (clk),
            .rstn    (rstn),
            .raw     (btn_raw[i]),
            .clean_n (btn_n_clean[i]),
            .pulse   (ch_pulse[i])
        );
    end

`ifdef BTN_MULTI_REJECT_EN
    logic [N_BTN-1:0] blocked;

    // A press is blocked if any other channel is held or pulsing in the same cycle.
    always_comb begin
        blocked = '0;
        for (int i = 0; i < N_BTN; i++) begin
            blocked[i] = |(((~btn_n_clean) | ch_pulse) & ~(N_BTN'(1) << i));
        end
        press_pulse = ch_pulse & ~blocked;
        multi_press = |(ch_pulse & blocked);
    end
`else
    assign press_pulse = ch_pulse;
    assign multi_press = 1'b0;
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - scoreboard bench for btn_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2
module tb_btn_conditioner;

    typedef struct {
        int         cyc;
        logic [2:0] pulse;
        logic       multi;
        logic [2:0] clean;
    } exp_t;

    logic       clk;
    logic       rstn;
    logic [2:0] btn_raw;
    logic [2:0] btn_n_clean;
    logic [2:0] press_pulse;
    logic       multi_press;

    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    int         t;
    exp_t       sb[$];
    exp_t       e;
    logic [2:0] prev_clean = 3'b111;

    btn_conditioner #(
        .N_BTN           (3),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .btn_raw     (btn_raw),
        .btn_n_clean (btn_n_clean),
        .press_pulse (press_pulse),
        .multi_press (multi_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_at(input int c, input logic [2:0] p, input logic m, input logic [2:0] cl);
        exp_t x;
        x.cyc   = c;
        x.pulse = p;
        x.multi = m;
        x.clean = cl;
        sb.push_back(x);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    // Any pulse, multi-press or level change is an output event and must match the queue head.
    always @(negedge clk) begin
        if (rstn && (press_pulse != 3'b000 || multi_press || btn_n_clean != prev_clean)) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event cyc=%0d pulse=%b multi=%b clean=%b required=no event",
                         cyc, press_pulse, multi_press, btn_n_clean);
            end else begin
                e = sb.pop_front();
                if (e.cyc != cyc || e.pulse !== press_pulse || e.multi !== multi_press
                    || e.clean !== btn_n_clean) begin
                    bad++;
                    $display("FAIL event actual cyc=%0d pulse=%b multi=%b clean=%b required cyc=%0d pulse=%b multi=%b clean=%b",
                             cyc, press_pulse, multi_press, btn_n_clean,
                             e.cyc, e.pulse, e.multi, e.clean);
                end
            end
        end
        prev_clean = btn_n_clean;
    end

    initial begin
        rstn    = 1'b0;
        btn_raw = 3'b111;
        idle(3);
        chk("reset_outputs", {btn_n_clean, press_pulse, multi_press}, 7'b111_000_0);
        rstn = 1'b1;
        idle(5);
        chk("idle_outputs", {btn_n_clean, press_pulse, multi_press}, 7'b111_000_0);

        // clean press and release on channel 0
        btn_raw = 3'b110;
        t = cyc;
        expect_at(t + 7, 3'b001, 1'b0, 3'b110);
        idle(20);
        btn_raw = 3'b111;
        t = cyc;
        expect_at(t + 7, 3'b000, 1'b0, 3'b111);
        idle(15);

        // bounce on channel 1: low 3, high 2, low 10
        btn_raw = 3'b101;
        idle(3);
        btn_raw = 3'b111;
        idle(2);
        btn_raw = 3'b101;
        t = cyc;
        expect_at(t + 7, 3'b010, 1'b0, 3'b101);
        idle(10);
        btn_raw = 3'b111;
        t = cyc;
        expect_at(t + 7, 3'b000, 1'b0, 3'b111);
        idle(15);

        // 3-cycle glitch on channel 2 must produce no event
        btn_raw = 3'b011;
        idle(3);
        btn_raw = 3'b111;
        idle(15);

        // reset while channel 2 is mid-debounce and still held
        btn_raw = 3'b011;
        idle(4);
        rstn = 1'b0;
        #1;
        chk("mid_reset_outputs", {btn_n_clean, press_pulse, multi_press}, 7'b111_000_0);
        idle(3);
        chk("mid_reset_hold", {btn_n_clean, press_pulse, multi_press}, 7'b111_000_0);
        rstn = 1'b1;
        t = cyc;
        expect_at(t + 7, 3'b100, 1'b0, 3'b011);
        idle(20);
        btn_raw = 3'b111;
        t = cyc;
        expect_at(t + 7, 3'b000, 1'b0, 3'b111);
        idle(15);

        // simultaneous press of channels 0 and 2
        btn_raw = 3'b010;
        t = cyc;
`ifdef BTN_MULTI_REJECT_EN
        expect_at(t + 7, 3'b000, 1'b1, 3'b010);
`else
        expect_at(t + 7, 3'b101, 1'b0, 3'b010);
`endif
        idle(20);
        btn_raw = 3'b111;
        t = cyc;
        expect_at(t + 7, 3'b000, 1'b0, 3'b111);
        idle(15);

        // long hold on channel 0: exactly one pulse
        btn_raw = 3'b110;
        t = cyc;
        expect_at(t + 7, 3'b001, 1'b0, 3'b110);
        idle(100);
        btn_raw = 3'b111;
        t = cyc;
        expect_at(t + 7, 3'b000, 1'b0, 3'b111);
        idle(15);

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL pending_events actual=%0d required=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
Input conditioning stage directly upstream of the safe-lock FSM. It takes the raw, active-low, bouncing push-button pins and synchronizes each one to clk. It debounces each button independently and produces two outputs: a clean active-low level that wires straight into the FSM's btn input, and a one-cycle active-high press pulse per button. The FSM's internal edge detector therefore only ever sees one clean transition per physical press.

Parameters:
N_BTN, 3, number of buttons (BTN[N_BTN-1:0])
SYNC_STAGES, 2, synchronizer flip-flop depth, minimum 2
DEBOUNCE_CYCLES, 1_000_000, stable-level cycles required to accept a change (20 ms at 50 MHz), minimum 2

Ports:
clk  input  1  system clock, 50 MHz
rstn  input  1  asynchronous active-low reset
btn_raw  input  N_BTN  raw button pins, active-low, asynchronous to clk
btn_n_clean  output  N_BTN  debounced level, active-low (0 = held); feeds the FSM's btn input
press_pulse  output  N_BTN  one-cycle active-high pulse per accepted press
multi_press  output  1  one-cycle pulse when simultaneous presses are rejected; tied 0 without the optional feature

Behaviour:
- Interface decision: one clock, clk; reset rstn is asynchronous, active-low.
- Reset values:
  - synchronizer flops all 1 (released)
  - every channel FSM in RELEASED, counter 0
  - btn_n_clean = all 1s
  - press_pulse = 0
  - multi_press = 0
- All outputs are registered. No combinational path from btn_raw to any output.
- Synchronizer:
  - SYNC_STAGES flops per bit.
  - sync[i] is the last stage.
- Per-channel FSM (states RELEASED, PRESS_WAIT, HELD, RELEASE_WAIT):
  - RELEASED: sync=0 -> PRESS_WAIT, counter cleared to 0.
  - PRESS_WAIT:
    - sync=1 -> RELEASED (bounce rejected, counter 0).
    - else if counter == DEBOUNCE_CYCLES-1 -> HELD.
    - else counter+1.
  - HELD: sync=1 -> RELEASE_WAIT, counter 0.
  - RELEASE_WAIT:
    - sync=0 -> HELD (counter 0).
    - else if counter == DEBOUNCE_CYCLES-1 -> RELEASED.
    - else counter+1.
- Output per channel:
  - btn_n_clean[i] = 0 in HELD and RELEASE_WAIT, 1 otherwise.
  - press_pulse[i] = 1 only for the first cycle in HELD that is entered from PRESS_WAIT.
  - Releases never pulse.
- Latency: take the first clk edge that samples btn_raw[i]=0 as edge 0. Then press_pulse[i] and btn_n_clean[i]=0 are visible in the cycle after edge SYNC_STAGES+DEBOUNCE_CYCLES. Release uses the same latency.
- Counter width is $clog2(DEBOUNCE_CYCLES). It never wraps: the state transition occurs at the terminal value.
- A button held indefinitely gives exactly one pulse. There is no auto-repeat.
- Reset mid-operation: everything returns to reset values immediately, with no pulse. A button still held after rstn deasserts is treated as a fresh press and pulses after full debounce latency.
- Simultaneous presses (feature off): channels are independent. press_pulse may carry more than one bit in the same cycle, and the FSM treats that as an incorrect digit.

Optional Feature:
BTN_MULTI_REJECT_EN
- Defined: press_pulse[i] is suppressed whenever either condition holds in the pulse cycle:
  - any other channel's btn_n_clean is 0;
  - any other channel also pulses.
  - In that cycle multi_press=1 for one cycle instead.
  - btn_n_clean levels are unaffected.
- Undefined: multi_press is constant 0 and pulses pass unfiltered.

Decomposition:
- Package btn_pkg holds:
  - the typedef enum logic [1:0] btn_state_t {RELEASED, PRESS_WAIT, HELD, RELEASE_WAIT}
  - localparams N_BTN_DEF=3, SYNC_STAGES_DEF=2, DEBOUNCE_CYCLES_DEF=1_000_000
- Sub-module btn_debounce_ch contains one synchronizer, FSM and counter per button. It is instantiated N_BTN times in a generate loop.
- The top level contains only the generate loop and the multi-press filter.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
- Clean press: btn_raw=3'b110 held 20 cycles, then 3'b111 -> press_pulse=3'b001 for one cycle after edge 6 and btn_n_clean=3'b110 from that cycle; btn_n_clean returns to 3'b111 after edge 6 of the release, with no pulse.
- Bounce: btn_raw[1] low 3 cycles, high 2, low 10 -> exactly one press_pulse=3'b010, after edge 6 counted from the final falling edge.
- Glitch: btn_raw[2] low for 3 cycles only -> press_pulse stays 0 and btn_n_clean stays 3'b111 throughout.
- Reset mid-debounce: rstn=0 while channel 2 is in PRESS_WAIT and the button is still held -> outputs 3'b111/3'b000 immediately; after rstn=1, one pulse 3'b100 follows at the full debounce latency.
- Simultaneous press: btn_raw=3'b010 from a single edge -> without the macro, press_pulse=3'b101 for one cycle; with BTN_MULTI_REJECT_EN, press_pulse=3'b000 and multi_press=1 for one cycle.
- Long hold: btn_raw[0] low 100 cycles -> exactly one press_pulse pulse.
